// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the MEM stage: accepts one load/store,
// stalls the pipeline for LATENCY BUSY cycles, then pulses mem_ready for one cycle.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        mem_misalign
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t             state;
    state_t             state_next;
    logic [3:0]         count;
    logic [ADDR_W-1:0]  idx_q;
    logic               we_q;
    logic [31:0]        wdata_q;
    logic               mis_q;
    logic               commit;
    logic [31:0]        mem [2**ADDR_W];

    // Upper byte-address bits are deliberately ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next   = state;
        commit       = 1'b0;
        mem_stall    = 1'b0;
        mem_ready    = 1'b0;
        mem_misalign = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = mem_req;
                if (mem_req) state_next = BUSY;
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (count == 4'd0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                mem_ready    = 1'b1;
                mem_misalign = mis_q;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) mem_stall = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            mis_q     <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && mem_req) begin
                idx_q   <= mem_addr[ADDR_W+1:2];
                we_q    <= mem_we;
                wdata_q <= mem_wdata;
                mis_q   <= (mem_addr[1:0] != 2'b00);
                count   <= COUNT_INIT;
            end else if (state == BUSY && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (commit && !we_q) mem_rdata <= mem[idx_q];
        end
    end

    // NOTE: the array has no reset; contents survive rst, and commit is low while rst holds state in IDLE.
    always_ff @(posedge clk) begin
        if (commit && we_q) mem[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, hand-written
// multi-cycle sequences, and random traffic against an array-based reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, we1, req2, we2;
    logic [31:0] addr1, wdata1, addr2, wdata2;
    logic [31:0] rdata1, rdata2;
    logic        ready1, stall1, mis1, ready2, stall2, mis2;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(ready1),
        .mem_stall(stall1), .mem_misalign(mis1)
    );

    data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(ready2),
        .mem_stall(stall2), .mem_misalign(mis2)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit which, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (which) begin
            req2 = req; we2 = we; addr2 = addr; wdata2 = wdata;
        end else begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // Reference model: plain word array indexed by address bits [9:2].
    function automatic logic [31:0] model_apply(input logic we, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        int idx = int'(addr[9:2]);
        if (we) model_mem[idx] = wdata;
        else model_rdata = model_mem[idx];
        return model_rdata;
    endfunction

    // One full transaction; samples on negedges and counts stall cycles before mem_ready.
    task automatic access(input bit which, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit scramble,
                          output logic [31:0] rdata, output logic mis,
                          output int stalls, output bit ok);
        logic rdy, stl;
        ok = 1'b0; stalls = 0; rdata = '0; mis = 1'b0;
        @(posedge clk); #1;
        drive(which, 1'b1, we, addr, wdata);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            rdy = which ? ready2 : ready1;
            stl = which ? stall2 : stall1;
            if (rdy && stl) check("ready_stall_exclusive", {31'd0, stl}, 32'd0);
            if (rdy) begin
                ok    = 1'b1;
                rdata = which ? rdata2 : rdata1;
                mis   = which ? mis2 : mis1;
                drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
            end else if (stl) begin
                stalls++;
                if (scramble && stalls >= 2)
                    drive(which, 1'b1, 1'($urandom), $urandom, $urandom);
            end
        end
        if (!ok) begin
            check("access_timeout", 32'd0, 32'd1);
            drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        @(negedge clk);
        rdy = which ? ready2 : ready1;
        stl = which ? stall2 : stall1;
        check("ready_one_cycle", {31'd0, rdy}, 32'd0);
        check("idle_no_stall", {31'd0, stl}, 32'd0);
    endtask

    task automatic run_op(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit scramble);
        logic [31:0] r, exp_r;
        logic m;
        int s;
        bit ok;
        exp_r = model_apply(we, addr, wdata);
        access(1'b0, we, addr, wdata, scramble, r, m, s, ok);
        check("rand_rdata", r, exp_r);
        check("rand_misalign", {31'd0, m}, {31'd0, addr[1:0] != 2'b00});
        check("rand_stall_cycles", s, 32'd3);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        logic        m;
        int          s;
        bit          ok;
        bit          found;
        int          gap;

        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        model_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_rdata", rdata1, 32'd0);
        check("reset_ready", {31'd0, ready1}, 32'd0);
        check("reset_stall_forced", {31'd0, stall1}, 32'd0);
        check("reset_misalign", {31'd0, mis1}, 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Preload every word so random loads have a known expected value.
        for (int i = 0; i < 256; i++) run_op(1'b1, i * 4, $urandom, 1'b0);

        vecs = '{
            '{1'b1, 32'h0000_0010, 32'h0000_00AB, 32'h0000_0000, 1'b0},
            '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_00AB, 1'b0},
            '{1'b1, 32'h0000_0400, 32'h0000_0055, 32'h0000_00AB, 1'b0},
            '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0055, 1'b0},
            '{1'b1, 32'h0000_0014, 32'h0000_0007, 32'h0000_0055, 1'b0},
            '{1'b0, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b1},
            '{1'b0, 32'h0000_0017, 32'h0,         32'h0000_0007, 1'b1},
            '{1'b1, 32'h0000_03FE, 32'h1234_5678, 32'h0000_0007, 1'b1},
            '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678, 1'b0}
        };
        foreach (vecs[i]) begin
            void'(model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata));
            access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, r, m, s, ok);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            check($sformatf("vec%0d_misalign", i), {31'd0, m}, {31'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d_stalls", i), s, 32'd3);
        end

        // Back-to-back loads with mem_req held across DONE.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (ready1) found = 1'b1;
        end
        check("b2b_first_ready", {31'd0, found}, 32'd1);
        check("b2b_first_rdata", rdata1, 32'h0000_00AB);
        addr1 = 32'h14;
        found = 1'b0;
        gap = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            gap++;
            if (ready1) found = 1'b1;
            else begin
                check("b2b_rdata_held", rdata1, 32'h0000_00AB);
                if (gap == 1) check("b2b_accept_stall", {31'd0, stall1}, 32'd1);
            end
        end
        check("b2b_second_ready", {31'd0, found}, 32'd1);
        check("b2b_gap", gap, 32'd4);
        check("b2b_second_rdata", rdata1, 32'd7);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        void'(model_apply(1'b0, 32'h14, 32'd0));
        @(negedge clk);

        // Reset during the first BUSY cycle of a store aborts it.
        run_op(1'b1, 32'h0C, 32'h1111_1111, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h0C, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("rst_mid_busy_stall", {31'd0, stall1}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_rdata", rdata1, 32'd0);
        check("rst_mid_ready", {31'd0, ready1}, 32'd0);
        check("rst_mid_stall", {31'd0, stall1}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 32'd0;
        access(1'b0, 1'b0, 32'h0C, 32'd0, 1'b0, r, m, s, ok);
        void'(model_apply(1'b0, 32'h0C, 32'd0));
        check("rst_store_aborted", r, 32'h1111_1111);

        // Random traffic, sometimes changing request fields during BUSY.
        for (int i = 0; i < 150; i++)
            run_op(1'($urandom), $urandom, $urandom, 1'($urandom));

        // LATENCY=1 instance.
        access(1'b1, 1'b1, 32'h08, 32'hCAFE_F00D, 1'b1, r, m, s, ok);
        check("lat1_store_stalls", s, 32'd2);
        access(1'b1, 1'b0, 32'h08, 32'd0, 1'b1, r, m, s, ok);
        check("lat1_load_stalls", s, 32'd2);
        check("lat1_load_rdata", r, 32'hCAFE_F00D);
        check("lat1_misalign", {31'd0, m}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory target answering the MEM stage's load/store requests. It sits behind MEM_STAGE: it accepts one request at a time, raises a stall to freeze the pipeline while the access is in flight, then returns read data with a one-cycle ready pulse. It lets LW/SW tests cover memory latency instead of a zero-wait array.

Parameters:
ADDR_W, 8, word-index width; the array holds 2^ADDR_W 32-bit words.
LATENCY, 2, number of BUSY cycles before the access completes; legal range is 1 to 15.

Ports:
clk  input  1  pipeline clock, rising-edge active
rst  input  1  asynchronous, active-high reset
mem_req  input  1  request valid; the requester holds it and all request fields stable while mem_stall=1
mem_we  input  1  1 = store (SW), 0 = load (LW)
mem_addr  input  32  byte address, normally EX_MEM_ALUResult
mem_wdata  input  32  store data, normally EX_MEM_WriteData
mem_rdata  output  32  load data
mem_ready  output  1  one-cycle completion pulse
mem_stall  output  1  pipeline hold request
mem_misalign  output  1  pulses with mem_ready when mem_addr[1:0] is not 2'b00

Behaviour:
- Reset (asynchronous, at any time):
  - state goes to IDLE; count = 0.
  - mem_rdata = 0, mem_ready = 0, mem_misalign = 0, mem_stall = 0.
  - An in-flight access is aborted; a store not yet committed is never written.
  - Array contents are not cleared.
- Word index = mem_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - mem_stall = mem_req, combinational, forced to 0 while rst=1.
  - On a clock edge with mem_req=1, latch index, we, wdata and the misalign flag; set count = LATENCY-1; go to BUSY.
  - With mem_req=0, stay in IDLE.
- BUSY:
  - mem_stall = 1.
  - If count != 0, decrement count.
  - If count == 0, commit the access and go to DONE:
    - store: write the latched wdata to the array.
    - load: register array[index] into mem_rdata.
- DONE:
  - mem_ready = 1 and mem_stall = 0 for exactly one cycle.
  - mem_misalign = the latched flag.
  - Always return to IDLE on the next edge.
  - mem_req is ignored in this cycle. If it is still high in the following IDLE cycle, it is treated as a new request.
- Latency: request first seen in cycle 0 → BUSY in cycles 1..LATENCY → mem_ready in cycle LATENCY+1. The pipeline stalls for LATENCY+1 cycles.
- mem_rdata holds its value until the next load completes. A store does not change mem_rdata.
- Misaligned access: the low two address bits are ignored for indexing. The access still completes normally, with mem_misalign raised alongside mem_ready.
- A load issued after a store to the same index returns the stored value; there is no stale read.
- Request fields changing during BUSY have no effect, because only the values latched at acceptance are used.
- mem_ready and mem_stall are never high together.

Test Plan:
1. Reset mid-store:
   - Setup: preload array[3] = 0x11111111.
   - Stimulus: SW of 0xDEADBEEF to addr 0x0C; assert rst during the first BUSY cycle; release; LW from 0x0C.
   - Required response: mem_rdata = 0x11111111; mem_ready, mem_stall and mem_rdata read 0 during reset.
2. Basic store/load, LATENCY=2:
   - Stimulus: SW of 0x000000AB to addr 0x10, then LW from 0x10.
   - Required response: each access has mem_stall high for 3 cycles, then mem_ready high for 1 cycle; load returns mem_rdata = 0x000000AB.
3. Back-to-back requests:
   - Stimulus: hold mem_req=1 across DONE, with LW 0x10 followed immediately by LW 0x14 (array[5] = 7).
   - Required response: the second request is accepted in the IDLE cycle after DONE; the second mem_ready carries mem_rdata = 7; mem_rdata = 0x000000AB is held between the two pulses.
4. Address wrap, ADDR_W=8:
   - Stimulus: SW of 0x55 to addr 0x400, then LW from 0x000.
   - Required response: LW returns 0x55.
5. Misaligned access:
   - Stimulus: LW from addr 0x13.
   - Required response: returns array[4]; mem_misalign = 1 in the mem_ready cycle only.
6. Minimum latency, LATENCY=1:
   - Stimulus: LW from addr 0x08.
   - Required response: mem_stall high for 2 cycles, mem_ready in cycle 2; changing mem_addr during BUSY does not alter the result.
